// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: PS/2 keyboard front end for the game controller.
// Receives PS/2 frames, decodes set-2 scan codes into controller commands
// (load, endinput, start, wipe, try) and the guessed-letter strobe/code.
// Optional feature macro: PS2_PARITY_CHK_EN -- when defined, odd parity over
// the 8 data bits plus the parity bit is checked, and a mismatch drops the byte.
module ps2_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       load,
    output logic       endinput,
    output logic       start,
    output logic       wipe,
    output logic       try,
    output logic       letter_valid,
    output logic [4:0] letter,
    output logic       frame_err
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

    // Synchronisers and edge detector. They reset to 1 because an idle PS/2
    // bus floats high; this avoids a phantom falling edge after reset.
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic ps2_fall;

    // Two-flop synchronise both PS/2 lines and keep the previous clock level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign ps2_fall = clk_prev & ~clk_s2;

    // Receiver -> decoder handshake: byte_ok is a single-cycle strobe with
    // rx_byte valid in the same cycle; there is no ready, the decoder always
    // consumes it (bytes arrive hundreds of cycles apart).
    rx_state_t             rx_state;
    logic [2:0]            bitcnt;
    logic [7:0]            shreg;
    logic [7:0]            rx_byte;
    logic                  byte_ok;
    logic [TIMEOUT_W-1:0]  to_cnt;
    logic                  par_good;

`ifdef PS2_PARITY_CHK_EN
    logic par_bit;
    assign par_good = ^{shreg, par_bit};
`else
    assign par_good = 1'b1;
`endif

    // Frame receiver: start/data/parity/stop bits plus the inter-edge timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state  <= RX_IDLE;
            bitcnt    <= 3'd0;
            shreg     <= 8'h00;
            rx_byte   <= 8'h00;
            byte_ok   <= 1'b0;
            frame_err <= 1'b0;
            to_cnt    <= '0;
`ifdef PS2_PARITY_CHK_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            byte_ok   <= 1'b0;
            frame_err <= 1'b0;
            if (ps2_fall) begin
                to_cnt <= '0;
                case (rx_state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            rx_state <= RX_DATA;
                            bitcnt   <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) rx_state <= RX_PAR;
                    end
                    RX_PAR: begin
`ifdef PS2_PARITY_CHK_EN
                        par_bit  <= dat_s2;
`endif
                        rx_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        rx_state <= RX_IDLE;
                        if (dat_s2 && par_good) begin
                            byte_ok <= 1'b1;
                            rx_byte <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (rx_state != RX_IDLE) begin
                if (to_cnt == TO_LAST) begin
                    frame_err <= 1'b1;
                    rx_state  <= RX_IDLE;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Set-2 letter codes: returns {hit, index} with index 0=A .. 25=Z.
    function automatic logic [5:0] letter_lookup(input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case (code)
            8'h1C: r = {1'b1, 5'd0};   8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};   8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};   8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};   8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};   8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};  8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};  8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};  8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};  8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};  8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};  8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};  8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};  8'h1A: r = {1'b1, 5'd25};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    logic [5:0]  lk;
    assign lk = letter_lookup(rx_byte);

    dec_state_t  dec_state;
    logic        held_enter, held_end, held_ins, held_del;
    logic [25:0] held_letter;

    // Scan-code decoder: prefix tracking, held flags and registered command outputs.
    // load doubles as the Space held flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dec_state    <= D_IDLE;
            load         <= 1'b0;
            held_enter   <= 1'b0;
            held_end     <= 1'b0;
            held_ins     <= 1'b0;
            held_del     <= 1'b0;
            held_letter  <= 26'd0;
            endinput     <= 1'b0;
            start        <= 1'b0;
            wipe         <= 1'b0;
            try          <= 1'b0;
            letter_valid <= 1'b0;
            letter       <= 5'd0;
        end else begin
            endinput     <= 1'b0;
            start        <= 1'b0;
            wipe         <= 1'b0;
            try          <= 1'b0;
            letter_valid <= 1'b0;
            if (byte_ok) begin
                case (dec_state)
                    D_IDLE: begin
                        if (rx_byte == 8'hE0) begin
                            dec_state <= D_EXT;
                        end else if (rx_byte == 8'hF0) begin
                            dec_state <= D_BRK;
                        end else if (rx_byte == 8'h29) begin
                            load <= 1'b1;
                        end else if (rx_byte == 8'h5A) begin
                            if (!held_enter) try <= 1'b1;
                            held_enter <= 1'b1;
                        end else if (lk[5] && !held_letter[lk[4:0]]) begin
                            letter_valid          <= 1'b1;
                            letter                <= lk[4:0];
                            held_letter[lk[4:0]]  <= 1'b1;
                        end
                    end
                    D_EXT: begin
                        if (rx_byte == 8'hF0) begin
                            dec_state <= D_EXT_BRK;
                        end else if (rx_byte != 8'hE0) begin
                            dec_state <= D_IDLE;
                            case (rx_byte)
                                8'h69: begin
                                    if (!held_end) endinput <= 1'b1;
                                    held_end <= 1'b1;
                                end
                                8'h70: begin
                                    if (!held_ins) start <= 1'b1;
                                    held_ins <= 1'b1;
                                end
                                8'h71: begin
                                    if (!held_del) wipe <= 1'b1;
                                    held_del <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    D_BRK: begin
                        dec_state <= D_IDLE;
                        if (rx_byte == 8'h29) load <= 1'b0;
                        else if (rx_byte == 8'h5A) held_enter <= 1'b0;
                        else if (lk[5]) held_letter[lk[4:0]] <= 1'b0;
                    end
                    D_EXT_BRK: begin
                        dec_state <= D_IDLE;
                        case (rx_byte)
                            8'h69:   held_end <= 1'b0;
                            8'h70:   held_ins <= 1'b0;
                            8'h71:   held_del <= 1'b0;
                            default: ;
                        endcase
                    end
                    default: dec_state <= D_IDLE;
                endcase
            end
        end
    end

endmodule
